// File: rtl/usb_tx_wire_arbiter_if.sv
// usb_tx_wire_arbiter_if: one requester's Req/Gnt/Rdy/WEn/Data/Ctrl bundle for the shared USB TX wire.
interface usb_tx_wire_arbiter_if;
  logic       req;
  logic       gnt;
  logic       rdy;
  logic       wen;
  logic [1:0] data;
  logic       ctrl;
  modport master(output req, wen, data, ctrl, input gnt, rdy);
  modport slave(input req, wen, data, ctrl, output gnt, rdy);
endinterface

// File: rtl/usb_tx_wire_arbiter.sv
// usb_tx_wire_arbiter: round-robin, non-preemptive sharing of the USB TX wire between two requesters,
// pacing accepted writes at one bit time (FS or LS) and flagging overruns.
module usb_tx_wire_arbiter #(
  parameter int FS_DIV = 4,
  parameter int LS_DIV = 32,
  parameter int CNT_W  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_full_speed_rate,
  usb_tx_wire_arbiter_if.slave          i_bus0,
  usb_tx_wire_arbiter_if.slave          i_bus1,
  output logic [1:0]                    o_tx_wire_data,
  output logic                          o_tx_wire_ctrl,
  output logic                          o_tx_wire_overrun
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GNT0    = 2'd1;
  localparam logic [1:0] GNT1    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;
  localparam logic [CNT_W-1:0] FS_LOAD = CNT_W'(FS_DIV - 1);
  localparam logic [CNT_W-1:0] LS_LOAD = CNT_W'(LS_DIV - 1);
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_gnt;
  logic [1:0]       r_data;
  logic             r_ctrl;
  logic             r_ovr;
  logic       w_bit_rdy, w_gnt0, w_gnt1, w_wr0, w_wr1, w_wr;
  logic       w_own_req, w_own_wen, w_release;
  logic [1:0] w_next;
  assign w_bit_rdy   = r_cnt == '0;
  assign w_gnt0      = r_state == GNT0;
  assign w_gnt1      = r_state == GNT1;
  assign i_bus0.gnt  = w_gnt0;
  assign i_bus1.gnt  = w_gnt1;
  assign i_bus0.rdy  = w_gnt0 & w_bit_rdy;
  assign i_bus1.rdy  = w_gnt1 & w_bit_rdy;
  assign w_wr0       = w_gnt0 & w_bit_rdy & i_bus0.wen;
  assign w_wr1       = w_gnt1 & w_bit_rdy & i_bus1.wen;
  assign w_wr        = w_wr0 | w_wr1;
  assign w_own_req   = w_gnt0 ? i_bus0.req : i_bus1.req;
  assign w_own_wen   = (w_gnt0 & i_bus0.wen) | (w_gnt1 & i_bus1.wen);
  // A write accepted with Req already low still owns the wire for its whole bit period.
  assign w_release   = (w_gnt0 | w_gnt1) & ~w_own_req & w_bit_rdy & ~w_own_wen;
  assign w_next      = r_state == RELEASE ? IDLE :
                       r_state == IDLE    ? ((i_bus0.req & i_bus1.req) ? (r_last_gnt ? GNT0 : GNT1) :
                                             i_bus0.req ? GNT0 : i_bus1.req ? GNT1 : IDLE) :
                       w_release          ? RELEASE : r_state;
  assign o_tx_wire_data    = r_data;
  assign o_tx_wire_ctrl    = r_ctrl;
  assign o_tx_wire_overrun = r_ovr;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last_gnt <= 1'b1;
      r_data     <= 2'b00;
      r_ctrl     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_wr ? (i_full_speed_rate ? FS_LOAD : LS_LOAD) :
                 w_bit_rdy ? r_cnt : r_cnt - CNT_W'(1);
      if (w_release) r_last_gnt <= w_gnt1;
      if (w_wr) begin
        r_data <= w_wr0 ? i_bus0.data : i_bus1.data;
        r_ctrl <= w_wr0 ? i_bus0.ctrl : i_bus1.ctrl;
      end else if (w_release) begin
        r_ctrl <= 1'b0;
      end
      if (w_own_wen & ~w_bit_rdy) r_ovr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_usb_tx_wire_arbiter.sv
// tb_usb_tx_wire_arbiter: directed + random stimulus; a timestamp-based reference model feeds a scoreboard
// that a separate monitor drains one expected output vector per clock.
module tb_usb_tx_wire_arbiter;
  localparam int FS = 4;
  localparam int LS = 32;
  logic clk, rst, fs;
  logic [1:0] tx_data;
  logic tx_ctrl, tx_ovr;
  usb_tx_wire_arbiter_if u0();
  usb_tx_wire_arbiter_if u1();
  usb_tx_wire_arbiter #(.FS_DIV(FS), .LS_DIV(LS), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .i_full_speed_rate(fs), .i_bus0(u0.slave), .i_bus1(u1.slave),
    .o_tx_wire_data(tx_data), .o_tx_wire_ctrl(tx_ctrl), .o_tx_wire_overrun(tx_ovr));
  initial clk = 0;
  always #5 clk = ~clk;
  logic [7:0] q[$];
  int n_chk = 0, n_err = 0;
  int m_owner, m_last;
  bit m_rel, m_ctrl, m_ovr;
  bit [1:0] m_data;
  longint m_next_ok, n_edge = 0;
  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (q.size() == 0) chk("scoreboard_underflow", 1, 0);
    else begin
      e = q.pop_front();
      chk("gnt0", u0.gnt, e[7]);
      chk("gnt1", u1.gnt, e[6]);
      chk("rdy0", u0.rdy, e[5]);
      chk("rdy1", u1.rdy, e[4]);
      chk("tx_data", tx_data, e[3:2]);
      chk("tx_ctrl", tx_ctrl, e[1]);
      chk("tx_overrun", tx_ovr, e[0]);
    end
  end
  // Model: owner id, a RELEASE gap flag, and the edge index at which the next bit may be written.
  task automatic tick();
    bit [1:0] rq, we;
    bit brdy, g0, g1;
    int o;
    rq = {u1.req, u0.req};
    we = {u1.wen, u0.wen};
    if (!rst) begin
      m_owner = -1; m_rel = 0; m_last = 1; m_data = 0; m_ctrl = 0; m_ovr = 0; m_next_ok = 0;
    end else begin
      brdy = n_edge >= m_next_ok;
      if (m_rel) m_rel = 0;
      else if (m_owner < 0) begin
        if (rq == 2'b11) m_owner = (m_last == 1) ? 0 : 1;
        else if (rq[0]) m_owner = 0;
        else if (rq[1]) m_owner = 1;
      end else begin
        o = m_owner;
        if (we[o]) begin
          if (brdy) begin
            m_data = o ? u1.data : u0.data;
            m_ctrl = o ? u1.ctrl : u0.ctrl;
            m_next_ok = n_edge + (fs ? FS : LS);
          end else m_ovr = 1;
        end else if (!rq[o] && brdy) begin
          m_last = o; m_owner = -1; m_rel = 1; m_ctrl = 0;
        end
      end
    end
    g0 = m_owner == 0;
    g1 = m_owner == 1;
    q.push_back({g0, g1, g0 && (n_edge + 1 >= m_next_ok), g1 && (n_edge + 1 >= m_next_ok), m_data, m_ctrl, m_ovr});
    n_edge++;
    @(negedge clk);
  endtask
  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask
  initial begin
    logic [1:0] pat[4];
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b00;
    rst = 0; fs = 1;
    u0.req = 1; u0.wen = 0; u0.data = 0; u0.ctrl = 0;
    u1.req = 1; u1.wen = 0; u1.data = 0; u1.ctrl = 0;
    ticks(3);
    rst = 1; u1.req = 0;
    ticks(3);
    u0.wen = 1; u0.ctrl = 1;
    for (int i = 0; i < 16; i++) begin u0.data = pat[(i / 4) % 4]; tick(); end
    u0.wen = 0; fs = 0;
    ticks(4);
    for (int k = 0; k < 4; k++) begin
      u0.wen = 1; u0.data = pat[k]; tick();
      u0.wen = 0; ticks(4);
      if (k == 0) begin u0.wen = 1; u0.data = 2'b11; tick(); u0.wen = 0; end
      ticks(30);
    end
    u0.req = 0; u1.req = 0; ticks(4);
    u0.req = 1; u1.req = 1; ticks(3);
    u0.req = 0; ticks(4);
    u0.req = 1; ticks(2);
    u1.req = 0; ticks(6);
    u0.req = 1; u1.req = 1; ticks(4);
    u0.req = 0; u1.req = 0; ticks(4);
    rst = 0; tick(); rst = 1;
    u0.req = 1; ticks(3);
    u0.wen = 1; u0.data = 2'b10; u0.ctrl = 1; tick();
    u0.wen = 0; u0.req = 0; tick();
    u1.req = 1;
    for (int i = 0; i < 34; i++) begin u1.wen = i[2]; u1.data = 2'(i); tick(); end
    u1.wen = 0; ticks(4);
    u1.wen = 1; u1.data = 2'b01; u1.ctrl = 1; tick(); u1.wen = 0;
    ticks(19);
    rst = 0; tick();
    rst = 1; u1.req = 1; u0.req = 0; ticks(3);
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 19) == 0) u0.req = ~u0.req;
      if ($urandom_range(0, 19) == 0) u1.req = ~u1.req;
      if ($urandom_range(0, 49) == 0) fs = ~fs;
      u0.wen = $urandom_range(0, 2) == 0; u0.data = 2'($urandom); u0.ctrl = 1'($urandom);
      u1.wen = $urandom_range(0, 2) == 0; u1.data = 2'($urandom); u1.ctrl = 1'($urandom);
      tick();
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
